// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Two-requester writeback arbiter for the 16x16 register file write port.
// req0 (ALU) and req1 (load/memory) use valid/ready handshakes. The winner
// is registered so the regfile sees at most one write per clock. A pending-
// write scoreboard lets decode check sources for RAW/WAW hazards.
//
// Build option: define WB_FIXED_PRIO_EN for fixed priority (req0 always wins
// contention). The default build uses round-robin between the two requesters.

module regfile_wb_arbiter #(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 4,
   localparam int NREGS  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,

   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,

   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,

   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [ADDR_W-1:0] chk_addr_0,
   input  logic [ADDR_W-1:0] chk_addr_1,
   output logic              chk_busy_0,
   output logic              chk_busy_1,
   output logic [NREGS-1:0]  busy
);

   logic              grant0;
   logic              grant1;
   logic              xfer0;
   logic              xfer1;

   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic [NREGS-1:0]  busy_q,    busy_d;
   logic [NREGS-1:0]  set_mask;
   logic [NREGS-1:0]  clr_mask;

`ifdef WB_FIXED_PRIO_EN

   // Fixed priority: req0 always wins, req1 only when req0 is idle.
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
   end

`else

   // last_grant_q = 1 means req1 won the most recent transfer; reset value 1
   // makes req0 the winner of the first contention.
   logic last_grant_q, last_grant_d;

   // Round-robin grant: under contention the requester not granted last wins.
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid;
      if (req0_valid && req1_valid) begin
         grant0 = last_grant_q;
         grant1 = ~last_grant_q;
      end
   end

   // Remember the winner only when a transfer actually completes.
   always_comb begin
      last_grant_d = last_grant_q;
      if (xfer0) begin
         last_grant_d = 1'b0;
      end else if (xfer1) begin
         last_grant_d = 1'b1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign xfer0      = req0_valid & grant0;
   assign xfer1      = req1_valid & grant1;

   // Capture the winning write; address/data hold while no transfer occurs.
   always_comb begin
      wr_en_d   = xfer0 | xfer1;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (xfer0) begin
         wr_addr_d = req0_addr;
         wr_data_d = req0_data;
      end else if (xfer1) begin
         wr_addr_d = req1_addr;
         wr_data_d = req1_data;
      end
   end

   // Write-port register; a handshake seen during reset is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Scoreboard next state: clear on commit, set on issue, set overrides clear
   // because the newly issued producer is still outstanding.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_en) begin
         set_mask = NREGS'(1) << issue_addr;
      end
      if (wr_en_q) begin
         clr_mask = NREGS'(1) << wr_addr_q;
      end
      busy_d = (busy_q & ~clr_mask) | set_mask;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Hazard lookups read the registered vector only, so a register reads
   // non-busy exactly when its committed value is visible in the regfile.
   assign chk_busy_0 = busy_q[chk_addr_0];
   assign chk_busy_1 = busy_q[chk_addr_1];

   assign rf_wr_en   = wr_en_q;
   assign rf_wr_addr = wr_addr_q;
   assign rf_wr_data = wr_data_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table followed by
// randomized traffic checked against a behavioural model.

module tb_regfile_wb_arbiter;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr,  req1_addr;
   logic [DW-1:0] req0_data,  req1_data;
   logic          req0_ready, req1_ready;
   logic          rf_wr_en;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic          issue_en;
   logic [AW-1:0] issue_addr, chk_addr_0, chk_addr_1;
   logic          chk_busy_0, chk_busy_1;
   logic [NR-1:0] busy;

   int n_vec = 0;
   int n_err = 0;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .chk_addr_0 (chk_addr_0),
      .chk_addr_1 (chk_addr_1),
      .chk_busy_0 (chk_busy_0),
      .chk_busy_1 (chk_busy_1),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rst;
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          iss;
      logic [AW-1:0] ia;
      logic [AW-1:0] c0;
      logic [AW-1:0] c1;
      logic          r0;
      logic          r1;
      logic          wen;
      logic          cw;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [NR-1:0] bz;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      logic rst, logic v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
      logic v1, logic [AW-1:0] a1, logic [DW-1:0] d1,
      logic iss, logic [AW-1:0] ia, logic [AW-1:0] c0, logic [AW-1:0] c1,
      logic r0, logic r1, logic wen, logic cw, logic [AW-1:0] wa,
      logic [DW-1:0] wd, logic [NR-1:0] bz);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.iss = iss; v.ia = ia; v.c0 = c0; v.c1 = c1;
      v.r0 = r0; v.r1 = r1; v.wen = wen; v.cw = cw;
      v.wa = wa; v.wd = wd; v.bz = bz;
      return v;
   endfunction

   task automatic build_table();
      // reset held with req0 valid, then first transfer after reset
      tbl.push_back(mk(1,1,2,16'h0111,0,0,0,     0,0,0,0, 1,0,0,1,0,16'h0000,16'h0000));
      tbl.push_back(mk(1,1,2,16'h0111,0,0,0,     0,0,0,0, 1,0,0,1,0,16'h0000,16'h0000));
      tbl.push_back(mk(0,1,2,16'h0111,0,0,0,     0,0,0,0, 1,0,0,1,0,16'h0000,16'h0000));
      tbl.push_back(mk(0,0,0,0,1,1,16'h0222,     0,0,0,0, 0,1,1,1,2,16'h0111,16'h0000));
      // contention, both held four cycles
`ifdef WB_FIXED_PRIO_EN
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 1,0,1,1,1,16'h0222,16'h0000));
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 1,0,1,1,3,16'hAAAA,16'h0000));
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 1,0,1,1,3,16'hAAAA,16'h0000));
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 1,0,1,1,3,16'hAAAA,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,               0,0,0,0, 0,0,1,1,3,16'hAAAA,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,               0,0,0,0, 0,0,0,1,3,16'hAAAA,16'h0000));
`else
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 1,0,1,1,1,16'h0222,16'h0000));
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 0,1,1,1,3,16'hAAAA,16'h0000));
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 1,0,1,1,5,16'h5555,16'h0000));
      tbl.push_back(mk(0,1,3,16'hAAAA,1,5,16'h5555, 0,0,0,0, 0,1,1,1,3,16'hAAAA,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,               0,0,0,0, 0,0,1,1,5,16'h5555,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,               0,0,0,0, 0,0,0,1,5,16'h5555,16'h0000));
`endif
      // scoreboard: issue 7, req1 writes 7 two cycles later
      tbl.push_back(mk(0,1,12,16'h0C0C,0,0,0,    0,0,0,0, 1,0,0,0,0,16'h0000,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,            1,7,7,0, 0,0,1,1,12,16'h0C0C,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,7,0, 0,0,0,1,12,16'h0C0C,16'h0080));
      tbl.push_back(mk(0,0,0,0,1,7,16'h7777,     0,0,7,0, 0,1,0,1,12,16'h0C0C,16'h0080));
      tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,7,0, 0,0,1,1,7,16'h7777,16'h0080));
      tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,7,0, 0,0,0,1,7,16'h7777,16'h0000));
      // simultaneous set/clear on register 9
      tbl.push_back(mk(0,0,0,0,1,9,16'h9999,     0,0,0,9, 0,1,0,1,7,16'h7777,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,            1,9,0,9, 0,0,1,1,9,16'h9999,16'h0000));
      tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,0,9, 0,0,0,1,9,16'h9999,16'h0200));
      tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,0,9, 0,0,0,1,9,16'h9999,16'h0200));
      // backpressure on req1, then re-issue to a busy bit and its commit
      tbl.push_back(mk(0,1,4,16'h4444,1,6,16'h1234, 0,0,0,9, 1,0,0,1,9,16'h9999,16'h0200));
      tbl.push_back(mk(0,0,0,0,1,6,16'h1234,     0,0,0,9, 0,1,1,1,4,16'h4444,16'h0200));
      tbl.push_back(mk(0,0,0,0,0,0,0,            1,9,0,9, 0,0,1,1,6,16'h1234,16'h0200));
      tbl.push_back(mk(0,1,9,16'h0000,0,0,0,     0,0,0,9, 1,0,0,1,6,16'h1234,16'h0200));
      tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,0,9, 0,0,1,1,9,16'h0000,16'h0200));
      tbl.push_back(mk(0,0,0,0,0,0,0,            0,0,0,9, 0,0,0,1,9,16'h0000,16'h0000));
   endtask

   // ---------------- behavioural reference model ----------------
   int            m_last;       // index of requester granted most recently
   logic          m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   bit            m_busy[NR];

   function automatic int model_winner(logic v0, logic v1);
`ifdef WB_FIXED_PRIO_EN
      if (v0) return 0;
      if (v1) return 1;
      return -1;
`else
      if (v0 && v1) return (m_last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
`endif
   endfunction

   function automatic logic [NR-1:0] model_busy_vec();
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // Advance the model across one rising edge using the present inputs.
   task automatic model_step();
      int w;
      bit nb[NR];
      if (reset) begin
         m_last  = 1;
         m_wen   = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
         for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (issue_en && int'(issue_addr) == i)        nb[i] = 1'b1;
            else if (m_wen && int'(m_waddr) == i)         nb[i] = 1'b0;
            else                                          nb[i] = m_busy[i];
         end
         m_busy = nb;
         w = model_winner(req0_valid, req1_valid);
         if (w == 0) begin
            m_wen = 1'b1; m_waddr = req0_addr; m_wdata = req0_data; m_last = 0;
         end else if (w == 1) begin
            m_wen = 1'b1; m_waddr = req1_addr; m_wdata = req1_data; m_last = 1;
         end else begin
            m_wen = 1'b0;
         end
      end
   endtask

   task automatic drive_idle();
      req0_valid = 0; req0_addr = 0; req0_data = 0;
      req1_valid = 0; req1_addr = 0; req1_data = 0;
      issue_en = 0; issue_addr = 0; chk_addr_0 = 0; chk_addr_1 = 0;
   endtask

   initial begin
      bit            p0_v, p1_v;
      logic [AW-1:0] p0_a, p1_a;
      logic [DW-1:0] p0_d, p1_d;
      int            w;
      logic [NR-1:0] mb;

      reset = 1'b1;
      drive_idle();
      build_table();

      foreach (tbl[k]) begin
         @(posedge clk);
         #1;
         reset      = tbl[k].rst;
         req0_valid = tbl[k].v0; req0_addr = tbl[k].a0; req0_data = tbl[k].d0;
         req1_valid = tbl[k].v1; req1_addr = tbl[k].a1; req1_data = tbl[k].d1;
         issue_en   = tbl[k].iss; issue_addr = tbl[k].ia;
         chk_addr_0 = tbl[k].c0;  chk_addr_1 = tbl[k].c1;
         @(negedge clk);
         check($sformatf("tbl%0d req0_ready", k), 32'(req0_ready), 32'(tbl[k].r0));
         check($sformatf("tbl%0d req1_ready", k), 32'(req1_ready), 32'(tbl[k].r1));
         check($sformatf("tbl%0d rf_wr_en", k),   32'(rf_wr_en),   32'(tbl[k].wen));
         if (tbl[k].cw) begin
            check($sformatf("tbl%0d rf_wr_addr", k), 32'(rf_wr_addr), 32'(tbl[k].wa));
            check($sformatf("tbl%0d rf_wr_data", k), 32'(rf_wr_data), 32'(tbl[k].wd));
         end
         check($sformatf("tbl%0d busy", k),       32'(busy),       32'(tbl[k].bz));
         check($sformatf("tbl%0d chk_busy_0", k), 32'(chk_busy_0), 32'(tbl[k].bz[tbl[k].c0]));
         check($sformatf("tbl%0d chk_busy_1", k), 32'(chk_busy_1), 32'(tbl[k].bz[tbl[k].c1]));
      end

      // Randomized traffic: reset for two cycles, then requesters that hold
      // valid/addr/data until granted, plus random issues and hazard probes.
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive_idle();
      model_step();
      @(posedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
      reset = 1'b0;
      p0_v = 0; p1_v = 0; p0_a = 0; p1_a = 0; p0_d = 0; p1_d = 0;

      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!p0_v && $urandom_range(0, 2) != 0) begin
            p0_v = 1; p0_a = AW'($urandom); p0_d = DW'($urandom);
         end
         if (!p1_v && $urandom_range(0, 2) != 0) begin
            p1_v = 1; p1_a = AW'($urandom); p1_d = DW'($urandom);
         end
         req0_valid = p0_v; req0_addr = p0_a; req0_data = p0_d;
         req1_valid = p1_v; req1_addr = p1_a; req1_data = p1_d;
         issue_en   = ($urandom_range(0, 3) == 0);
         issue_addr = AW'($urandom);
         chk_addr_0 = AW'($urandom);
         chk_addr_1 = AW'($urandom);

         w  = model_winner(p0_v, p1_v);
         mb = model_busy_vec();
         @(negedge clk);
         check("rnd req0_ready", 32'(req0_ready), 32'(w == 0));
         check("rnd req1_ready", 32'(req1_ready), 32'(w == 1));
         check("rnd rf_wr_en",   32'(rf_wr_en),   32'(m_wen));
         check("rnd rf_wr_addr", 32'(rf_wr_addr), 32'(m_waddr));
         check("rnd rf_wr_data", 32'(rf_wr_data), 32'(m_wdata));
         check("rnd busy",       32'(busy),       32'(mb));
         check("rnd chk_busy_0", 32'(chk_busy_0), 32'(m_busy[chk_addr_0]));
         check("rnd chk_busy_1", 32'(chk_busy_1), 32'(m_busy[chk_addr_1]));
         model_step();
         if (w == 0) p0_v = 0;
         if (w == 1) p1_v = 0;
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 16x16 register file between two writeback requesters, req0 (ALU) and req1 (load/memory).
- Uses valid/ready handshakes and round-robin arbitration.
- Registers the winning write, so the regfile sees at most one write per clock.
- Keeps a 16-bit pending-write scoreboard that decode queries for RAW/WAW hazards before issuing.

Parameters:
- DATA_W, 16, width of write data.
- ADDR_W, 4, register address width; register count NREGS = 2**ADDR_W (16).

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  ADDR_W  requester 0 destination register
- req0_data  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 granted this cycle (combinational)
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  ADDR_W  requester 1 destination register
- req1_data  input  DATA_W  requester 1 write data
- req1_ready  output  1  requester 1 granted this cycle (combinational)
- rf_wr_en  output  1  registered write enable to regfile
- rf_wr_addr  output  ADDR_W  registered write address to regfile
- rf_wr_data  output  DATA_W  registered write data to regfile
- issue_en  input  1  decode issued an instruction that will write issue_addr
- issue_addr  input  ADDR_W  destination of the issued instruction
- chk_addr_0, chk_addr_1  input  ADDR_W  source registers to hazard-check
- chk_busy_0, chk_busy_1  output  1  source register has a write pending (combinational)
- busy  output  NREGS  full scoreboard vector, registered

Behaviour:
- Reset (sync, high), outputs and state on the clock edge:
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, busy=0.
  - last_grant=1, so req0 wins the first contention after reset.
  - Any in-flight handshake in the reset cycle is dropped.
- Handshake: transfer occurs when reqN_valid && reqN_ready. Requesters hold valid/addr/data stable until ready. Ready never depends on anything other than both valids and last_grant.
- Arbitration, combinational, at most one ready high per cycle:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - Neither valid: both readies low.
- last_grant updates only on a completed transfer.
- Write register: one-cycle latency. The cycle after a transfer, rf_wr_en=1 with the granted addr/data; otherwise rf_wr_en=0. rf_wr_addr/data hold their last value while rf_wr_en=0.
- Back-to-back transfers produce rf_wr_en high on consecutive cycles, giving full throughput of 1 write/cycle.
- Scoreboard, per bit i, on each posedge:
  - Set if issue_en && issue_addr==i.
  - Cleared if rf_wr_en && rf_wr_addr==i, i.e. clearing coincides with the regfile commit edge.
  - Set and clear on the same bit in the same cycle: set wins (new producer pending).
  - Clear of a non-busy bit: no effect, no error.
  - Issue to an already-busy bit: stays 1; no producer count is kept. Decode must stall instead of issuing a second writer to a busy register.
- chk_busy_k = busy[chk_addr_k], taken from the registered vector with no same-cycle clear bypass. A register reads non-busy the cycle after its write commits, matching regfile async read of the committed value.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority. req0 always wins contention; req1 is granted only when req0_valid=0. last_grant is unused and may be removed.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset then idle: hold reset 2 cycles with req0_valid=1 -> rf_wr_en=0 and busy=0 throughout reset. First cycle after reset: req0_ready=1; next cycle rf_wr_en=1, rf_wr_addr=req0_addr.
- Contention: req0 (addr 3, data 16'hAAAA) and req1 (addr 5, data 16'h5555) both valid and held for 4 cycles -> grants 0,1,0,1. rf_wr_addr sequence 3,5,3,5, one cycle delayed, rf_wr_en continuously 1.
- Scoreboard: issue_en with addr 7, then a req1 write to 7 two cycles later -> busy[7]=1 and chk_busy_0=1 for chk_addr_0=7 until the rf_wr_en cycle; busy[7]=0 the following cycle.
- Simultaneous set/clear: rf_wr_en=1 to addr 9 in the same cycle as issue_en to addr 9 -> busy[9] remains 1.
- Backpressure: req1 valid and held while req0 valid for 1 cycle -> req1_ready=0 that cycle; req1 data 16'h1234 is written the next cycle with no loss or duplication.
- With WB_FIXED_PRIO_EN: both requesters valid and held for 3 cycles -> req0 granted all 3 cycles, req1_ready=0 throughout.
